// File: rtl/sram_addr_walk_test_if.sv
// Handshake bundle between the address-walk engine and the shared SRAM
// controller: one mem strobe per operation, accepted while ready is high.
interface sram_addr_walk_test_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
);
  logic              mem;
  logic              rw;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data2ram;
  logic [DATA_W-1:0] data2fpga;

  modport master (
    output mem,
    output rw,
    output addr,
    output data2ram,
    input  ready,
    input  data2fpga
  );

  modport slave (
    input  mem,
    input  rw,
    input  addr,
    input  data2ram,
    output ready,
    output data2fpga
  );
endinterface

// File: rtl/sram_addr_walk_test.sv
// SRAM address-bus walking-bit test engine.
// Fills every walking-bit slot with the background PATTERN, then for each
// test slot t writes ~PATTERN, reads back all slots, and restores slot t.
// A read that differs from the expected value captures the address, the
// expected data and the observed data, and ends the test with result=0.
// Optional macro ADDR_WALK_ZEROS_EN: after a passing walking-ones pass a
// second pass runs around the all-ones base (walking zeros), and the
// fail_phase output records which pass produced the miscompare.
module sram_addr_walk_test #(
  parameter int                 ADDR_W  = 20,
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  PATTERN = {DATA_W/2{2'b10}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  sram_addr_walk_test_if.master  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [DATA_W-1:0]      fail_exp,
  output logic [DATA_W-1:0]      fail_act
`ifdef ADDR_WALK_ZEROS_EN
  ,
  output logic                   fail_phase
`endif
);

  localparam int              CW        = $clog2(ADDR_W + 1);
  localparam logic [CW-1:0]   LAST_SLOT = CW'(ADDR_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    CMP    = 3'd4,
    REINIT = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      t;
  logic [CW-1:0]      t_next;
  logic [CW-1:0]      r;
  logic [CW-1:0]      r_next;
  logic               result_next;
  logic [ADDR_W-1:0]  fail_addr_next;
  logic [DATA_W-1:0]  fail_exp_next;
  logic [DATA_W-1:0]  fail_act_next;
  logic [ADDR_W-1:0]  base;
  logic [DATA_W-1:0]  cmp_expected;

`ifdef ADDR_WALK_ZEROS_EN
  logic phase;
  logic phase_next;
  logic fail_phase_next;

  // The second pass walks zeros through an all-ones base address.
  assign base = phase ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
`else
  assign base = {ADDR_W{1'b0}};
`endif

  // Only the slot currently under test holds the inverted data.
  assign cmp_expected = (r == t) ? ~PATTERN : PATTERN;

  // Slot 0 is the base itself; slot k flips address bit k-1 of the base.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [CW-1:0]     idx);
    logic [ADDR_W-1:0] onehot;
    onehot = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (idx == CW'(i + 1)) begin
        onehot[i] = 1'b1;
      end
    end
    return b ^ onehot;
  endfunction

  // State, slot counters and captured results, all loaded from the
  // next-state logic; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      t         <= '0;
      r         <= '0;
      result    <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
`ifdef ADDR_WALK_ZEROS_EN
      phase      <= 1'b0;
      fail_phase <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      t         <= t_next;
      r         <= r_next;
      result    <= result_next;
      fail_addr <= fail_addr_next;
      fail_exp  <= fail_exp_next;
      fail_act  <= fail_act_next;
`ifdef ADDR_WALK_ZEROS_EN
      phase      <= phase_next;
      fail_phase <= fail_phase_next;
`endif
    end
  end

  // Sequencing: each op state advances only on a ready cycle, which is also
  // the cycle its single mem pulse is issued.
  always_comb begin
    state_next     = state;
    t_next         = t;
    r_next         = r;
    result_next    = result;
    fail_addr_next = fail_addr;
    fail_exp_next  = fail_exp;
    fail_act_next  = fail_act;
`ifdef ADDR_WALK_ZEROS_EN
    phase_next      = phase;
    fail_phase_next = fail_phase;
`endif
    case (state)
      IDLE: begin
        if (en) begin
          result_next    = 1'b0;
          fail_addr_next = '0;
          fail_exp_next  = '0;
          fail_act_next  = '0;
          t_next         = '0;
          r_next         = '0;
`ifdef ADDR_WALK_ZEROS_EN
          phase_next      = 1'b0;
          fail_phase_next = 1'b0;
`endif
          state_next     = INIT;
        end
      end
      INIT: begin
        if (bus.ready) begin
          if (r == LAST_SLOT) begin
            r_next     = '0;
            state_next = WRITE;
          end else begin
            r_next = r + 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.ready) begin
          state_next = READ;
        end
      end
      READ: begin
        if (bus.ready) begin
          state_next = CMP;
        end
      end
      CMP: begin
        if (bus.ready) begin
          if (bus.data2fpga != cmp_expected) begin
            fail_addr_next = slot_addr(base, r);
            fail_exp_next  = cmp_expected;
            fail_act_next  = bus.data2fpga;
            result_next    = 1'b0;
`ifdef ADDR_WALK_ZEROS_EN
            fail_phase_next = phase;
`endif
            state_next     = DONE;
          end else if (r != LAST_SLOT) begin
            r_next     = r + 1'b1;
            state_next = READ;
          end else if (t != LAST_SLOT) begin
            r_next     = '0;
            state_next = REINIT;
          end else begin
`ifdef ADDR_WALK_ZEROS_EN
            if (!phase) begin
              phase_next = 1'b1;
              t_next     = '0;
              r_next     = '0;
              state_next = INIT;
            end else begin
              result_next = 1'b1;
              state_next  = DONE;
            end
`else
            result_next = 1'b1;
            state_next  = DONE;
`endif
          end
        end
      end
      REINIT: begin
        if (bus.ready) begin
          t_next     = t + 1'b1;
          state_next = WRITE;
        end
      end
      DONE: begin
        if (!en) begin
          state_next = IDLE;
        end
      end
      default: begin
        result_next = 1'b0;
        state_next  = DONE;
      end
    endcase
  end

  // Bus drive and status decode; mem is forced low whenever reset is held.
  always_comb begin
    bus.mem      = 1'b0;
    bus.rw       = 1'b1;
    bus.addr     = '0;
    bus.data2ram = '0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      INIT: begin
        bus.mem      = bus.ready;
        bus.rw       = 1'b0;
        bus.addr     = slot_addr(base, r);
        bus.data2ram = PATTERN;
      end
      WRITE: begin
        bus.mem      = bus.ready;
        bus.rw       = 1'b0;
        bus.addr     = slot_addr(base, t);
        bus.data2ram = ~PATTERN;
      end
      READ: begin
        bus.mem  = bus.ready;
        bus.addr = slot_addr(base, r);
      end
      CMP: begin
        bus.mem = 1'b0;
      end
      REINIT: begin
        bus.mem      = bus.ready;
        bus.rw       = 1'b0;
        bus.addr     = slot_addr(base, t);
        bus.data2ram = PATTERN;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
    if (!rst_n) begin
      bus.mem = 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_addr_walk_test.sv
// Directed bench for sram_addr_walk_test at ADDR_W=4, DATA_W=8, PATTERN=0xAA
// with a behavioural 16-byte SRAM that can alias address bit 2 to zero.
module tb_sram_addr_walk_test;

  typedef struct packed {
    logic       rw;
    logic [3:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       busy;
  logic       done;
  logic       result;
  logic [3:0] fail_addr;
  logic [7:0] fail_exp;
  logic [7:0] fail_act;
`ifdef ADDR_WALK_ZEROS_EN
  logic       fail_phase;
`endif

  int   checks = 0;
  int   errors = 0;
  int   fault_mode = 0;
  bit   rand_ready = 1'b0;
  int   ready_violations = 0;
  op_t  log_q[$];
  op_t  exp_q[$];
  logic [7:0] sram [16];

  sram_addr_walk_test_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  sram_addr_walk_test #(.ADDR_W(4), .DATA_W(8), .PATTERN(8'hAA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_act  (fail_act)
`ifdef ADDR_WALK_ZEROS_EN
    ,
    .fail_phase(fail_phase)
`endif
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Physical address seen by the array, optionally with bit 2 stuck at 0
  function automatic logic [3:0] phys(input logic [3:0] a);
    return (fault_mode == 1) ? (a & 4'hB) : a;
  endfunction

  // Behavioural SRAM: performs and logs every accepted operation
  always @(posedge clk) begin
    if (bus.mem) begin
      if (bus.rw) begin
        bus.data2fpga <= sram[phys(bus.addr)];
      end else begin
        sram[phys(bus.addr)] <= bus.data2ram;
      end
      log_q.push_back({bus.rw, bus.addr, bus.rw ? 8'h00 : bus.data2ram});
      if (!bus.ready) ready_violations++;
    end
  end

  // Controller ready: steady high or a coin flip each cycle
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Runaway guard
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [3:0] slotOf(input logic [3:0] b, input int k);
    logic [3:0] onehot;
    onehot = '0;
    if (k > 0) onehot[k-1] = 1'b1;
    return b ^ onehot;
  endfunction

  // Expected operation list for a memory without faults
  task automatic buildExpected();
    logic [3:0] b;
    int passes;
    exp_q.delete();
`ifdef ADDR_WALK_ZEROS_EN
    passes = 2;
`else
    passes = 1;
`endif
    for (int p = 0; p < passes; p++) begin
      b = (p == 0) ? 4'h0 : 4'hF;
      for (int k = 0; k <= 4; k++) exp_q.push_back({1'b0, slotOf(b, k), 8'hAA});
      for (int t = 0; t <= 4; t++) begin
        exp_q.push_back({1'b0, slotOf(b, t), 8'h55});
        for (int k = 0; k <= 4; k++) exp_q.push_back({1'b1, slotOf(b, k), 8'h00});
        if (t < 4) exp_q.push_back({1'b0, slotOf(b, t), 8'hAA});
      end
    end
  endtask

  task automatic checkOps(input string tag);
    int bad;
    int n;
    bad = 0;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) bad++;
    checkOutput({tag, "_count"}, log_q.size(), exp_q.size());
    checkOutput({tag, "_seq_bad"}, bad, 0);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done"}, done, 1);
  endtask

  task automatic applyStimulus(input bit rand_rdy, input int fault);
    en = 1'b0;
    @(negedge clk);
    rand_ready = rand_rdy;
    fault_mode = fault;
    log_q.delete();
    en = 1'b1;
  endtask

  initial begin
    logic [3:0] init_exp [5];
    int n;
    init_exp = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < 16; i++) sram[i] = 8'h00;
    buildExpected();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_fail_addr", fail_addr, 0);
    checkOutput("rst_mem", bus.mem, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good memory, ready always high
    log_q.delete();
    en = 1'b1;
    waitDone("good");
    checkOutput("good_result", result, 1);
    checkOutput("good_busy", busy, 0);
    checkOutput("good_fail_addr", fail_addr, 0);
    checkOutput("good_fail_exp", fail_exp, 0);
    checkOutput("good_fail_act", fail_act, 0);
`ifdef ADDR_WALK_ZEROS_EN
    checkOutput("good_ops_total", log_q.size(), 78);
    init_exp = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7};
    for (int i = 0; i < 5; i++)
      if (log_q.size() > 39 + i)
        checkOutput($sformatf("zeros_init_addr%0d", i), log_q[39+i].addr, init_exp[i]);
`else
    checkOutput("good_ops_total", log_q.size(), 39);
    for (int i = 0; i < 5; i++)
      if (log_q.size() > i)
        checkOutput($sformatf("init_addr%0d", i), log_q[i].addr, init_exp[i]);
`endif
    checkOps("good");

    // Done holds while en stays high
    repeat (3) @(negedge clk);
    checkOutput("hold_done", done, 1);

    // Re-arm without reset
    en = 1'b0;
    @(negedge clk);
    checkOutput("idle_done", done, 0);
    log_q.delete();
    en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rerun_busy", busy, 1);
    checkOutput("rerun_result", result, 0);
    waitDone("rerun");
    checkOutput("rerun_result_end", result, 1);
    checkOps("rerun");

    // Address bit 2 stuck at 0
    applyStimulus(1'b0, 1);
    waitDone("stuck");
    checkOutput("stuck_result", result, 0);
    checkOutput("stuck_fail_addr", fail_addr, 4'h4);
    checkOutput("stuck_fail_exp", fail_exp, 8'hAA);
    checkOutput("stuck_fail_act", fail_act, 8'h55);
`ifdef ADDR_WALK_ZEROS_EN
    checkOutput("stuck_fail_phase", fail_phase, 0);
`endif

    // Failure record clears on the next start
    applyStimulus(1'b0, 0);
    repeat (2) @(negedge clk);
    checkOutput("clear_fail_addr", fail_addr, 0);
    checkOutput("clear_fail_act", fail_act, 0);
    waitDone("clear");
    checkOutput("clear_result", result, 1);

    // Random ready stalls
    ready_violations = 0;
    applyStimulus(1'b1, 0);
    waitDone("stall");
    checkOutput("stall_result", result, 1);
    checkOutput("stall_mem_without_ready", ready_violations, 0);
    checkOps("stall");
    rand_ready = 1'b0;

    // Reset in the middle of a read
    applyStimulus(1'b0, 0);
    n = 0;
    while (!(bus.mem && bus.rw) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_read_seen", bus.mem && bus.rw, 1);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    checkOutput("midrst_mem_gated", bus.mem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_mem", bus.mem, 0);
    log_q.delete();
    en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("restart_ops", log_q.size() > 0, 1);
    if (log_q.size() > 0) begin
      checkOutput("restart_first_rw", log_q[0].rw, 0);
      checkOutput("restart_first_addr", log_q[0].addr, 4'h0);
      checkOutput("restart_first_data", log_q[0].data, 8'hAA);
    end
    waitDone("restart");
    checkOutput("restart_result", result, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
